lcd_spi_responder: RTL
======================

LCD_SPI_RESPONDER -- requirements
Module: lcd_spi_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, received-frame buffer depth (power of 2, 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer flops per SPI pin (2..3).
REQ-003 SHALL have port clk  input  1  system clock; the single clock; at least 4x SCLK frequency.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock from the master (mode 0).
REQ-006 SHALL have port spi_ss_n  input  1  active-low slave select.
REQ-007 SHALL have port spi_mosi  input  1  serial data from the master.
REQ-008 SHALL have port spi_miso  output  1  serial readback data.
REQ-009 SHALL have port spi_miso_oe  output  1  MISO output-enable.
REQ-010 SHALL have port rx_valid  output  1  FIFO head holds a frame.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts the head frame.
REQ-012 SHALL have port rx_dc  output  1  frame D/C bit: 0 = command, 1 = data.
REQ-013 SHALL have port rx_data  output  8  frame payload byte.
REQ-014 SHALL have port tx_data  input  8  readback byte, shifted out on MISO.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse for an aborted partial frame.
REQ-016 SHALL have port rx_overflow  output  1  one-cycle pulse for a frame dropped because the FIFO was full.

Function
REQ-017 SHALL pass spi_sclk, spi_ss_n and spi_mosi through SYNC_STAGES flops each, then detect SCLK rising and falling edges against a registered copy.
REQ-018 SHALL use a two-state FSM: IDLE (ss_n high) and SHIFT (ss_n low).
REQ-019 SHALL move IDLE->SHIFT on synchronized ss_n low with bit count 0, and SHIFT->IDLE on synchronized ss_n high.
REQ-020 SHALL ignore SCLK edges in IDLE.
REQ-021 SHALL, in SHIFT, sample MOSI on each SCLK rising edge, MSB-first, as a 9-bit frame: bit 0 = D/C, bits 1..8 = data[7:0].
REQ-022 SHALL, on the 9th sample, write {dc, data} to the FIFO and wrap the bit count to 0, so back-to-back frames need no ss_n toggle.
REQ-023 SHALL assert rx_valid exactly SYNC_STAGES+2 clk cycles after the clk edge that first sees the 9th SCLK rise at the pin.
REQ-024 SHALL pop the FIFO head on a cycle with rx_valid && rx_ready; rx_dc/rx_data SHALL be stable while rx_valid is high and not popped.
REQ-025 SHALL, on a write to a full FIFO, drop the new frame, leave contents unchanged and pulse rx_overflow; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-026 SHALL, on SHIFT->IDLE with bit count 1..8, discard the partial frame and pulse frame_err; count 0 SHALL produce no pulse.
REQ-027 SHALL drive the FIFO as first-in first-out, with occupancy 0..FIFO_DEPTH and pointer wrap-around at FIFO_DEPTH.

Reset
REQ-028 SHALL, during reset, force FSM=IDLE, bit count=0, FIFO empty, synchronizers to ss_n=1/sclk=0/mosi=0, rx_valid=0, rx_dc=0, rx_data=0, frame_err=0, rx_overflow=0, spi_miso=0, spi_miso_oe=0.
REQ-029 SHALL discard a frame in progress when reset asserts mid-frame, with no frame_err pulse after release.

Configuration
REQ-030 SHALL compile readback only with macro LCD_SPI_RESP_READBACK_EN defined.
REQ-031 SHALL, with the macro, latch tx_data at frame start (bit count 0 in SHIFT), drive spi_miso from the tx_data MSB on the falling edge after the D/C bit, shift one bit per subsequent falling edge, and drive spi_miso_oe = registered ~ss_n.
REQ-032 SHALL, without the macro, hold spi_miso=0 and spi_miso_oe=0, and leave tx_data unused.

Structure
REQ-033 SHALL put constants FRAME_BITS=9, the FSM state enum (IDLE, SHIFT) and the frame typedef {dc, data[7:0]} in package lcd_spi_resp_pkg.
REQ-034 SHALL implement the buffer as sub-module lcd_spi_resp_fifo (sync FIFO with push/pop/full/empty).

Verification
REQ-035 SHALL test a single frame: ss_n low, send 9'b0_0010_1100 (cmd 0x2C), ss_n high -> one rx_valid with rx_dc=0, rx_data=0x2C; no frame_err.
REQ-036 SHALL test back-to-back frames: one ss_n window with cmd 0x2A then data 0x00, 0xEF -> three frames in order (dc 0,1,1); rx_ready held low until all three are buffered.
REQ-037 SHALL test an abort: ss_n high after 5 bits -> one frame_err pulse, no rx_valid; the next full frame data 0x55 is received correctly.
REQ-038 SHALL test overflow: FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 -> one rx_overflow pulse; pops return 0x01..0x04.
REQ-039 SHALL test readback with LCD_SPI_RESP_READBACK_EN and tx_data=0xA5 -> MISO bits 1..8 read 1,0,1,0,0,1,0,1; spi_miso_oe=1 only while ss_n is low.
REQ-040 SHALL test reset mid-frame: assert reset after 4 bits -> all outputs at reset values; after release, frame data 0x3C is received cleanly.

Source files
------------

// File: rtl/lcd_spi_resp_pkg.sv
// rtl/lcd_spi_resp_pkg.sv - shared constants and types for the LCD SPI responder
package lcd_spi_resp_pkg;

  localparam int FRAME_BITS = 9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } frame_t;

endpackage

// File: rtl/lcd_spi_resp_fifo.sv
// rtl/lcd_spi_resp_fifo.sv - synchronous frame FIFO; head is zero while empty
module lcd_spi_resp_fifo
  import lcd_spi_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  frame_t din,
  input  logic   pop,
  output frame_t dout,
  output logic   full,
  output logic   empty,
  output logic   drop
);

  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_spi_responder.sv
// rtl/lcd_spi_responder.sv - mode-0 SPI slave for 9-bit LCD D/C frames into a FIFO
// MISO readback is built only when LCD_SPI_RESP_READBACK_EN is defined.
module lcd_spi_responder
  import lcd_spi_resp_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_dc,
  output logic [7:0] rx_data,
  input  logic [7:0] tx_data,
  output logic       frame_err,
  output logic       rx_overflow
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The rising edge and its MOSI sample are registered together so they stay aligned.
  logic sclk_d;
  logic rise_q;
  logic mosi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0;
      rise_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      rise_q <= sclk_s && !sclk_d;
      mosi_q <= mosi_s;
    end
  end

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  logic [3:0] bit_cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!ss_s && bit_cnt == 4'd0) state_d = SHIFT;
      SHIFT: if (ss_s) state_d = IDLE;
    endcase
  end

  logic [7:0] shift_q;
  logic       push_q;
  frame_t     frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 4'd0;
      shift_q   <= 8'd0;
      push_q    <= 1'b0;
      frame_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      if (state_q == SHIFT && ss_s) begin
        bit_cnt   <= 4'd0;
        frame_err <= (bit_cnt != 4'd0);
      end else if (state_q == SHIFT && rise_q) begin
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          push_q  <= 1'b1;
          frame_q <= {shift_q, mosi_q};
          bit_cnt <= 4'd0;
        end else begin
          shift_q <= {shift_q[6:0], mosi_q};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  frame_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_drop;

  lcd_spi_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (frame_q),
    .pop   (rx_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign rx_valid = !fifo_empty;
  assign rx_dc    = head.dc;
  assign rx_data  = head.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_overflow <= 1'b0;
    else       rx_overflow <= fifo_drop;
  end

`ifdef LCD_SPI_RESP_READBACK_EN
  // Falling edge is taken unregistered to give MISO as much setup as possible.
  logic       fall;
  logic [7:0] tx_q;

  assign fall = !sclk_s && sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q        <= 8'd0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= !ss_s;
      if (state_q != SHIFT) begin
        spi_miso <= 1'b0;
      end else if (bit_cnt == 4'd0 && !rise_q) begin
        tx_q <= tx_data;
      end else if (fall && bit_cnt != 4'd0) begin
        spi_miso <= tx_q[7];
        tx_q     <= {tx_q[6:0], 1'b0};
      end
    end
  end
`else
  logic unused_tx;

  assign unused_tx   = ^tx_data;
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
`endif

endmodule
